// File: rtl/toggle_monitor.sv
// toggle_monitor: edge detector, edge counter, half-period timer and stall FSM for a toggle waveform.
// Define TOGGLE_MONITOR_SYNC_EN to pass i_toggle through a 2-flop synchronizer before edge detection.
module toggle_monitor (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        i_toggle,
  input  logic [31:0] i_timeout,
  input  logic        i_clr,
  output logic        o_edge,
  output logic [15:0] o_edge_cnt,
  output logic [31:0] o_half_period,
  output logic        o_period_valid,
  output logic        o_stall,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_prev;
  logic [31:0] r_timer;
  logic        w_sample;
  logic        w_ready;
  logic        w_edge;
  logic        w_timeout;

`ifdef TOGGLE_MONITOR_SYNC_EN
  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_warm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= i_toggle;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
    end
  end

  assign w_sample = r_sync2;
  // Hold IDLE after reset until the synchronizer carries a real sample, so the
  // reset value of the sync chain is never mistaken for a transition.
  assign w_ready  = r_warm[1];
`else
  assign w_sample = i_toggle;
  assign w_ready  = 1'b1;
`endif

  assign w_edge    = (w_sample ^ r_prev) & enable & (r_state != IDLE);
  assign w_timeout = (i_timeout != '0) && (r_timer >= i_timeout);
  assign o_state   = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_prev         <= 1'b0;
      r_timer        <= '0;
      o_edge         <= 1'b0;
      o_edge_cnt     <= '0;
      o_half_period  <= '0;
      o_period_valid <= 1'b0;
      o_stall        <= 1'b0;
    end else begin
      r_prev         <= w_sample;
      o_edge         <= w_edge;
      o_period_valid <= 1'b0;

      if (!enable) begin
        r_state       <= IDLE;
        r_timer       <= '0;
        o_edge_cnt    <= '0;
        o_half_period <= '0;
        o_stall       <= 1'b0;
      end else begin
        // An edge always wins over a coincident timeout.
        if (w_edge) begin
          r_state <= RUN;
          o_stall <= 1'b0;
          if ((r_state == RUN) && !i_clr) begin
            o_half_period  <= r_timer;
            o_period_valid <= 1'b1;
          end
        end else if (r_state == IDLE) begin
          if (w_ready) begin
            r_state <= ARM;
          end
        end else if ((r_state != STALL) && w_timeout) begin
          r_state <= STALL;
          o_stall <= 1'b1;
        end

        if (i_clr || (r_state == IDLE)) begin
          r_timer <= '0;
        end else if (w_edge) begin
          r_timer <= 32'd1;
        end else if (r_timer != '1) begin
          r_timer <= r_timer + 32'd1;
        end

        if (i_clr) begin
          o_edge_cnt    <= '0;
          o_half_period <= '0;
        end else if (w_edge) begin
          o_edge_cnt <= o_edge_cnt + 16'd1;
        end
      end
    end
  end

endmodule
